// File: rtl/blink_rate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : blink_rate_ctrl
// Description : KEY synchroniser/debouncer, 2-bit blink-rate stepper and
//               rate-dependent tick divider driving the blink LED block.
// Revision    : 1.0 - initial release
// ============================================================================
module blink_rate_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BASE_DIV        = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_n,
    output logic       press,
    output logic [1:0] rate,
    output logic       tick
);

    // The synchroniser resets to "released", so up to two post-reset samples
    // of s2 can be stale; release qualification never accepts fewer than that.
    localparam int c_qual_max = (DEBOUNCE_CYCLES < 2) ? 2 : DEBOUNCE_CYCLES;
    localparam int c_db_w     = $clog2(c_qual_max + 1);
    localparam int c_tc_w     = $clog2(BASE_DIV);

    localparam logic [c_db_w-1:0] c_db_term   = c_db_w'(DEBOUNCE_CYCLES);
    localparam logic [c_db_w-1:0] c_qual_term = c_db_w'(c_qual_max);
    localparam logic [c_tc_w-1:0] c_tc_last0  = c_tc_w'((BASE_DIV >> 0) - 1);
    localparam logic [c_tc_w-1:0] c_tc_last1  = c_tc_w'((BASE_DIV >> 1) - 1);
    localparam logic [c_tc_w-1:0] c_tc_last2  = c_tc_w'((BASE_DIV >> 2) - 1);
    localparam logic [c_tc_w-1:0] c_tc_last3  = c_tc_w'((BASE_DIV >> 3) - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_HELD   = 2'd2,
        ST_DISARM = 2'd3
    } db_state_t;

    logic              s1_q, s2_q;
    db_state_t         state_q, state_d;
    logic [c_db_w-1:0] db_cnt_q, db_cnt_d;
    logic              rel_ok_q, rel_ok_d;
    logic              press_q, press_d;
    logic [1:0]        rate_q, rate_d;
    logic              tick_q, tick_d;
    logic [c_tc_w-1:0] tick_cnt_q, tick_cnt_d;
    logic [c_tc_w-1:0] w_tc_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            state_q    <= ST_IDLE;
            db_cnt_q   <= '0;
            rel_ok_q   <= 1'b0;
            press_q    <= 1'b0;
            rate_q     <= 2'd0;
            tick_q     <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            s1_q       <= key_n;
            s2_q       <= s1_q;
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            rel_ok_q   <= rel_ok_d;
            press_q    <= press_d;
            rate_q     <= rate_d;
            tick_q     <= tick_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Until a qualified release is seen after reset, IDLE refuses to arm, so a
    // button held through reset must be released and pressed again.
    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        rel_ok_d = rel_ok_q;
        press_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rel_ok_q) begin
                    if (!s2_q) begin
                        db_cnt_d = '0;
                    end else if (db_cnt_q == c_qual_term) begin
                        rel_ok_d = 1'b1;
                        db_cnt_d = '0;
                    end else begin
                        db_cnt_d = db_cnt_q + 1'b1;
                    end
                end else if (!s2_q) begin
                    state_d  = ST_ARM;
                    db_cnt_d = c_db_w'(1);
                end
            end
            ST_ARM: begin
                if (s2_q) begin
                    state_d  = ST_IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == c_db_term) begin
                    state_d  = ST_HELD;
                    db_cnt_d = '0;
                    press_d  = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (s2_q) begin
                    state_d  = ST_DISARM;
                    db_cnt_d = c_db_w'(1);
                end
            end
            ST_DISARM: begin
                if (!s2_q) begin
                    state_d  = ST_HELD;
                    db_cnt_d = '0;
                end else if (db_cnt_q == c_db_term) begin
                    state_d  = ST_IDLE;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                db_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        case (rate_q)
            2'd0:    w_tc_last = c_tc_last0;
            2'd1:    w_tc_last = c_tc_last1;
            2'd2:    w_tc_last = c_tc_last2;
            default: w_tc_last = c_tc_last3;
        endcase
    end

    // Terminal count uses the old rate, so a coinciding press still emits the
    // old period's tick; a rate change always restarts the period from zero.
    always_comb begin
        rate_d = press_d ? rate_q + 2'd1 : rate_q;
        tick_d = (tick_cnt_q == w_tc_last);
        if (press_d || tick_d) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end
    end

    assign press = press_q;
    assign rate  = rate_q;
    assign tick  = tick_q;

endmodule
`default_nettype wire
